pcie_us_cfg_mgmt_resp: RTL and testbench
========================================

// Module: pcie_us_cfg_mgmt_resp
// PURPOSE
//   Responder for the UltraScale+ PCIe cfg_mgmt port: the hard-IP side of the interface driven by fpga_core.
//   Implements a small dword-addressed register file and answers reads/writes with a cfg_mgmt_read_write_done pulse.
//   Stands in for the hard IP config space in simulation; used on hardware as an FPGA-side shadow config register bank.
// PARAMETERS
//   REG_COUNT       16            number of 32-bit registers, dword addresses 0..REG_COUNT-1 (2..1024)
//   RESP_LATENCY    2             cycles from request acceptance to done pulse (1..15)
//   ID_VALUE        32'h9038_10ee read-only value of register 0
//   FUNC_NUM        8'd0          function number served (used only with CFG_MGMT_RESP_FUNC_CHECK_EN)
// PORTS
//   clk                       in   1   PCIe user clock, all logic on rising edge
//   rst                       in   1   synchronous active-high reset
//   cfg_mgmt_addr             in   10  dword address
//   cfg_mgmt_function_number  in   8   target function
//   cfg_mgmt_write            in   1   write request, held by initiator until done
//   cfg_mgmt_write_data       in   32  write data
//   cfg_mgmt_byte_enable      in   4   per-byte write enable, bit n -> data[8n+7:8n]
//   cfg_mgmt_read             in   1   read request, held by initiator until done
//   cfg_mgmt_read_data        out  32  read data, valid only while done is high, else 0
//   cfg_mgmt_read_write_done  out  1   single-cycle completion pulse
//   status_busy               out  1   high from acceptance until end of HOLD
// BEHAVIOUR
//   Reset: outputs 0, FSM IDLE, latency counter 0, registers 1..REG_COUNT-1 = 0; reg 0 is constant ID_VALUE.
//   FSM IDLE -> WAIT -> DONE -> HOLD -> IDLE.
//   IDLE: when read|write is high, accept: latch addr, data, byte_enable, function, op; go to WAIT; busy=1.
//     Write and read both high: treat as write, no read performed, read_data 0.
//   WAIT: count down RESP_LATENCY-1 cycles (0 cycles if RESP_LATENCY=1); input changes are ignored.
//   DONE: done=1 for exactly one cycle; a write commits on this edge; a read drives its data on this cycle.
//     Acceptance in cycle 0 gives done in cycle RESP_LATENCY.
//   HOLD: one cycle, requests ignored, so a request still held by the initiator is not accepted twice; then IDLE.
//     Back-to-back accesses: next acceptance no earlier than cycle RESP_LATENCY+2.
//   Write: reg[a][8n+7:8n] <= data[8n+7:8n] for each set byte_enable bit n; byte_enable=0 completes as a no-op.
//   Read: data = reg[a], sampled on the DONE cycle (reflects any earlier committed write).
//   Reg 0 is read-only: writes are dropped, done still pulses.
//   Out of range (addr >= REG_COUNT): read returns 0, write is dropped, done still pulses; no error output.
//   rst during WAIT/DONE/HOLD: immediate return to IDLE; the pending write is not committed; done stays 0
//     from the cycle after rst.
// CONFIGURATION
//   CFG_MGMT_RESP_FUNC_CHECK_EN defined: an access whose latched function != FUNC_NUM completes normally
//     (same latency, done pulse) but the write is dropped and the read returns 0.
//   Not defined: function number is ignored; all functions alias the same register file.
// TESTING
//   Reset, then read addr 0 -> done in cycle 2 after acceptance, read_data=32'h9038_10ee, then busy low.
//   Write addr 3 data 32'hAABBCCDD be=4'b0101, then read addr 3 -> 32'h00BB00DD.
//   Hold read high for 10 cycles at addr 3 -> exactly one done per 4-cycle slot (accept, WAIT, DONE, HOLD); no extra done.
//   Write addr 0 and addr REG_COUNT with 32'hFFFFFFFF -> both get done; reads return ID_VALUE and 0.
//   Write addr 5 32'h1234, assert rst in WAIT -> no done; after reset, read addr 5 -> 32'h0.
//   FUNC_CHECK_EN, FUNC_NUM=0: write fn=1 addr 2 32'h55 -> done; read fn=0 addr 2 -> 0; without the macro -> 32'h55.

Source files
------------

// File: rtl/pcie_us_cfg_mgmt_resp.sv
// ---------------------------------------------------------------------------
// pcie_us_cfg_mgmt_resp
//
// Purpose
//   Responder for the UltraScale+ PCIe cfg_mgmt port: the hard-IP side of
//   the interface. It holds a small dword-addressed register file and
//   answers every read or write with a one-cycle cfg_mgmt_read_write_done
//   pulse. In simulation it stands in for the hard IP config space; on
//   hardware it serves as an FPGA-side shadow config register bank.
//
// Parameters
//   REG_COUNT     number of 32-bit registers, dword addresses 0..REG_COUNT-1
//                 (2..1024)
//   RESP_LATENCY  cycles from request acceptance to the done pulse (1..15)
//   ID_VALUE      read-only value of register 0
//   FUNC_NUM      function number served (only with the macro below)
//
// Optional feature
//   CFG_MGMT_RESP_FUNC_CHECK_EN : when defined, an access whose latched
//   function number differs from FUNC_NUM completes normally (same latency,
//   done pulse) but its write is dropped and its read returns 0. When not
//   defined, the function number is ignored and all functions alias the
//   same register file.
//
// Ports
//   clk                       in   1   PCIe user clock, rising edge
//   rst                       in   1   synchronous active-high reset
//   cfg_mgmt_addr             in   10  dword address
//   cfg_mgmt_function_number  in   8   target function
//   cfg_mgmt_write            in   1   write request, held until done
//   cfg_mgmt_write_data       in   32  write data
//   cfg_mgmt_byte_enable      in   4   bit n enables data[8n+7:8n]
//   cfg_mgmt_read             in   1   read request, held until done
//   cfg_mgmt_read_data        out  32  read data, valid only with done, else 0
//   cfg_mgmt_read_write_done  out  1   single-cycle completion pulse
//   status_busy               out  1   high from acceptance until end of HOLD
//
// Handshake
//   The initiator raises cfg_mgmt_read or cfg_mgmt_write (with address,
//   data, byte enables and function) and holds it until it sees done. The
//   responder samples the request on the first edge it is in IDLE, ignores
//   the inputs afterwards, raises done for exactly one cycle RESP_LATENCY
//   cycles after acceptance, then spends one HOLD cycle ignoring requests
//   so a request still held on the done cycle is not accepted twice.
//   Write and read high together is treated as a write only.
// ---------------------------------------------------------------------------
module pcie_us_cfg_mgmt_resp #(
    parameter int          REG_COUNT    = 16,
    parameter int          RESP_LATENCY = 2,
    parameter logic [31:0] ID_VALUE     = 32'h9038_10ee,
    parameter logic [7:0]  FUNC_NUM     = 8'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  cfg_mgmt_addr,
    input  logic [7:0]  cfg_mgmt_function_number,
    input  logic        cfg_mgmt_write,
    input  logic [31:0] cfg_mgmt_write_data,
    input  logic [3:0]  cfg_mgmt_byte_enable,
    input  logic        cfg_mgmt_read,
    output logic [31:0] cfg_mgmt_read_data,
    output logic        cfg_mgmt_read_write_done,
    output logic        status_busy
);

    localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    // WAIT lasts RESP_LATENCY-1 cycles: the counter is loaded with
    // RESP_LATENCY-2 and WAIT exits on the cycle it reads zero.
    localparam logic [3:0] WAIT_LOAD = (RESP_LATENCY >= 2) ? 4'(RESP_LATENCY - 2) : 4'd0;

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    logic [9:0]  lat_addr;
    logic [31:0] lat_data;
    logic [3:0]  lat_be;
    logic        lat_write;
    logic        lat_read;

    // Entry 0 is never written; register 0 reads back ID_VALUE instead.
    logic [31:0] reg_q [REG_COUNT];

    logic          req;
    logic          in_range;
    logic          is_id;
    logic          func_ok;
    logic [AW-1:0] reg_idx;
    logic [31:0]   rd_value;
    logic          wr_commit;

`ifdef CFG_MGMT_RESP_FUNC_CHECK_EN
    logic [7:0] lat_fn;

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_fn <= 8'd0;
        end else if (state == S_IDLE && req) begin
            lat_fn <= cfg_mgmt_function_number;
        end
    end

    assign func_ok = (lat_fn == FUNC_NUM);
`else
    // Function number is deliberately not used in this build.
    logic unused_fn;
    assign unused_fn = ^cfg_mgmt_function_number;
    assign func_ok   = 1'b1;
`endif

    assign req      = cfg_mgmt_read | cfg_mgmt_write;
    assign in_range = (int'({22'd0, lat_addr}) < REG_COUNT);
    assign is_id    = (lat_addr == 10'd0);
    assign reg_idx  = lat_addr[AW-1:0];

    always_comb begin
        rd_value = 32'd0;
        if (is_id) begin
            rd_value = ID_VALUE;
        end else if (in_range) begin
            rd_value = reg_q[reg_idx];
        end
    end

    assign wr_commit = (state == S_DONE) && lat_write && in_range && !is_id && func_ok;

    // Control FSM and request latches
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            lat_addr  <= 10'd0;
            lat_data  <= 32'd0;
            lat_be    <= 4'd0;
            lat_write <= 1'b0;
            lat_read  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        lat_addr  <= cfg_mgmt_addr;
                        lat_data  <= cfg_mgmt_write_data;
                        lat_be    <= cfg_mgmt_byte_enable;
                        lat_write <= cfg_mgmt_write;
                        // Write wins when both are raised.
                        lat_read  <= cfg_mgmt_read & ~cfg_mgmt_write;
                        wait_cnt  <= WAIT_LOAD;
                        state     <= (RESP_LATENCY <= 1) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    state <= S_HOLD;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Register file: reset clears everything; a write commits on the edge
    // that ends the DONE cycle, byte lane by byte lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                reg_q[i] <= 32'd0;
            end
        end else if (wr_commit) begin
            for (int n = 0; n < 4; n++) begin
                if (lat_be[n]) begin
                    reg_q[reg_idx][8*n +: 8] <= lat_data[8*n +: 8];
                end
            end
        end
    end

    assign cfg_mgmt_read_write_done = (state == S_DONE);
    assign cfg_mgmt_read_data       = ((state == S_DONE) && lat_read && func_ok) ? rd_value : 32'd0;
    assign status_busy              = (state != S_IDLE);

endmodule

// File: tb/tb_pcie_us_cfg_mgmt_resp.sv
module tb_pcie_us_cfg_mgmt_resp;

    localparam int          REG_COUNT    = 16;
    localparam int          RESP_LATENCY = 2;
    localparam logic [31:0] ID_VALUE     = 32'h9038_10ee;

    logic        clk;
    logic        rst;
    logic [9:0]  cfg_mgmt_addr;
    logic [7:0]  cfg_mgmt_function_number;
    logic        cfg_mgmt_write;
    logic [31:0] cfg_mgmt_write_data;
    logic [3:0]  cfg_mgmt_byte_enable;
    logic        cfg_mgmt_read;
    logic [31:0] cfg_mgmt_read_data;
    logic        cfg_mgmt_read_write_done;
    logic        status_busy;

    int checks = 0;
    int errors = 0;

    pcie_us_cfg_mgmt_resp #(
        .REG_COUNT   (REG_COUNT),
        .RESP_LATENCY(RESP_LATENCY),
        .ID_VALUE    (ID_VALUE),
        .FUNC_NUM    (8'd0)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .cfg_mgmt_addr           (cfg_mgmt_addr),
        .cfg_mgmt_function_number(cfg_mgmt_function_number),
        .cfg_mgmt_write          (cfg_mgmt_write),
        .cfg_mgmt_write_data     (cfg_mgmt_write_data),
        .cfg_mgmt_byte_enable    (cfg_mgmt_byte_enable),
        .cfg_mgmt_read           (cfg_mgmt_read),
        .cfg_mgmt_read_data      (cfg_mgmt_read_data),
        .cfg_mgmt_read_write_done(cfg_mgmt_read_write_done),
        .status_busy             (status_busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        cfg_mgmt_write           = 1'b0;
        cfg_mgmt_read            = 1'b0;
        cfg_mgmt_addr            = 10'd0;
        cfg_mgmt_write_data      = 32'd0;
        cfg_mgmt_byte_enable     = 4'd0;
        cfg_mgmt_function_number = 8'd0;
    endtask

    // ---------------- driver ----------------
    // Raises a request, waits for done (bounded), checks latency, read data
    // on the done cycle, and the HOLD / return-to-IDLE cycles after it.
    task automatic do_access(input logic wr, input logic rd, input logic [9:0] addr,
                             input logic [31:0] data, input logic [3:0] be,
                             input logic [7:0] fn, input logic [31:0] exp,
                             input string name);
        int  n;
        bit  seen;
        cfg_mgmt_write           = wr;
        cfg_mgmt_read            = rd;
        cfg_mgmt_addr            = addr;
        cfg_mgmt_write_data      = data;
        cfg_mgmt_byte_enable     = be;
        cfg_mgmt_function_number = fn;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (cfg_mgmt_read_write_done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no done within 20 cycles", name);
            idle_inputs();
        end else begin
            check({name, " latency"}, 32'(n), 32'(RESP_LATENCY));
            check({name, " rdata"}, cfg_mgmt_read_data, exp);
            check({name, " busy_done"}, {31'd0, status_busy}, 32'd1);
            idle_inputs();
            tick();
            check({name, " hold_done"}, {31'd0, cfg_mgmt_read_write_done}, 32'd0);
            check({name, " hold_rdata"}, cfg_mgmt_read_data, 32'd0);
            check({name, " hold_busy"}, {31'd0, status_busy}, 32'd1);
            tick();
            check({name, " idle_busy"}, {31'd0, status_busy}, 32'd0);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        wr;
        logic        rd;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [7:0]  fn;
        logic [31:0] exp;
        string       name;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

`ifdef CFG_MGMT_RESP_FUNC_CHECK_EN
    localparam logic [31:0] FN_ALIAS_EXP = 32'h0;
`else
    localparam logic [31:0] FN_ALIAS_EXP = 32'h55;
`endif

    initial begin
        int dones;
        vecs[0]  = '{1'b0, 1'b1, 10'd0,    32'h0,         4'h0,    8'd0, ID_VALUE,      "rd_id"};
        vecs[1]  = '{1'b1, 1'b0, 10'd3,    32'hAABBCCDD,  4'b0101, 8'd0, 32'h0,         "wr3_be5"};
        vecs[2]  = '{1'b0, 1'b1, 10'd3,    32'h0,         4'h0,    8'd0, 32'h00BB00DD,  "rd3"};
        vecs[3]  = '{1'b1, 1'b0, 10'd0,    32'hFFFFFFFF,  4'hF,    8'd0, 32'h0,         "wr_id"};
        vecs[4]  = '{1'b1, 1'b0, 10'd16,   32'hFFFFFFFF,  4'hF,    8'd0, 32'h0,         "wr_oor"};
        vecs[5]  = '{1'b0, 1'b1, 10'd0,    32'h0,         4'h0,    8'd0, ID_VALUE,      "rd_id2"};
        vecs[6]  = '{1'b0, 1'b1, 10'd16,   32'h0,         4'h0,    8'd0, 32'h0,         "rd_oor"};
        vecs[7]  = '{1'b1, 1'b0, 10'd7,    32'h11223344,  4'h0,    8'd0, 32'h0,         "wr7_be0"};
        vecs[8]  = '{1'b0, 1'b1, 10'd7,    32'h0,         4'h0,    8'd0, 32'h0,         "rd7_noop"};
        vecs[9]  = '{1'b1, 1'b0, 10'd7,    32'hDEADBEEF,  4'hF,    8'd0, 32'h0,         "wr7_full"};
        vecs[10] = '{1'b1, 1'b0, 10'd7,    32'h11000000,  4'b1000, 8'd0, 32'h0,         "wr7_b3"};
        vecs[11] = '{1'b0, 1'b1, 10'd7,    32'h0,         4'h0,    8'd0, 32'h11ADBEEF,  "rd7_merge"};
        vecs[12] = '{1'b1, 1'b1, 10'd3,    32'h0,         4'hF,    8'd0, 32'h0,         "wr_rd_both"};
        vecs[13] = '{1'b0, 1'b1, 10'd3,    32'h0,         4'h0,    8'd0, 32'h0,         "rd3_after_both"};
        vecs[14] = '{1'b1, 1'b0, 10'd2,    32'h55,        4'hF,    8'd1, 32'h0,         "wr2_fn1"};
        vecs[15] = '{1'b0, 1'b1, 10'd2,    32'h0,         4'h0,    8'd0, FN_ALIAS_EXP,  "rd2_fn0"};

        // Reset
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_done", {31'd0, cfg_mgmt_read_write_done}, 32'd0);
        check("reset_rdata", cfg_mgmt_read_data, 32'd0);
        check("reset_busy", {31'd0, status_busy}, 32'd0);

        // Table
        for (int i = 0; i < NVEC; i++) begin
            do_access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data,
                      vecs[i].be, vecs[i].fn, vecs[i].exp, vecs[i].name);
        end
        do_access(1'b0, 1'b1, 10'd1023, 32'h0, 4'h0, 8'd0, 32'h0, "rd_1023");

        // Read held high for 12 edges: done only after edges 2, 6, 10.
        cfg_mgmt_addr = 10'd3;
        cfg_mgmt_read = 1'b1;
        dones = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (cfg_mgmt_read_write_done === 1'b1) dones++;
            check($sformatf("held_done_%0d", i), {31'd0, cfg_mgmt_read_write_done},
                  ((i % 4) == 2) ? 32'd1 : 32'd0);
            check($sformatf("held_busy_%0d", i), {31'd0, status_busy},
                  ((i % 4) == 0) ? 32'd0 : 32'd1);
        end
        check("held_done_count", 32'(dones), 32'd3);
        idle_inputs();
        tick();

        // Populate reg 6, then reset mid-write to reg 5.
        do_access(1'b1, 1'b0, 10'd6, 32'hCAFEF00D, 4'hF, 8'd0, 32'h0, "wr6");
        do_access(1'b0, 1'b1, 10'd6, 32'h0, 4'h0, 8'd0, 32'hCAFEF00D, "rd6");
        cfg_mgmt_write       = 1'b1;
        cfg_mgmt_addr        = 10'd5;
        cfg_mgmt_write_data  = 32'h1234;
        cfg_mgmt_byte_enable = 4'hF;
        tick();
        check("rst_wait_busy", {31'd0, status_busy}, 32'd1);
        rst = 1'b1;
        tick();
        check("rst_done", {31'd0, cfg_mgmt_read_write_done}, 32'd0);
        check("rst_busy", {31'd0, status_busy}, 32'd0);
        rst = 1'b0;
        idle_inputs();
        tick();
        check("post_rst_done", {31'd0, cfg_mgmt_read_write_done}, 32'd0);
        do_access(1'b0, 1'b1, 10'd5, 32'h0, 4'h0, 8'd0, 32'h0, "rd5_after_rst");
        do_access(1'b0, 1'b1, 10'd6, 32'h0, 4'h0, 8'd0, 32'h0, "rd6_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
